// File: rtl/awg_cmd_ctrl.sv
// rtl/awg_cmd_ctrl.sv - UART byte-stream command parser driving AWG config registers
// Parses W/F/A/legacy-digit commands, commits atomically and returns a one-byte ack.
module awg_cmd_ctrl #(
    parameter logic [31:0] FREQ_DEFAULT = 32'h0005_3E2D,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [4:0]  wave_sel,
    output logic [31:0] freq_word,
    output logic [7:0]  amp,
    output logic        cfg_update,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_W_ARG, S_W_END, S_HEX_ARG, S_DISCARD} state_t;

    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] ACK_E = 8'h45;

    function automatic logic is_d(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h34);
    endfunction

    function automatic logic [4:0] d_map(input logic [7:0] b);
        logic [4:0] v;
        case (b)
            8'h31:   v = 5'd0;
            8'h32:   v = 5'd1;
            8'h33:   v = 5'd2;
            8'h34:   v = 5'd3;
            default: v = 5'd10;
        endcase
        return v;
    endfunction

    function automatic logic is_t(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters A-F / a-f have low nibble 1..6, so adding 9 yields 10..15.
    function automatic logic [3:0] hex_nib(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
    endfunction

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] tmo_q, tmo_d;
    logic [4:0]  wave_sel_q, wave_sel_d;
    logic [31:0] freq_word_q, freq_word_d;
    logic [7:0]  amp_q, amp_d;
    logic        cfg_update_q, cfg_update_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        ack_new;
    logic [7:0]  ack_byte;
    logic [3:0]  hex_max;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        wave_sel_d   = wave_sel_q;
        freq_word_d  = freq_word_q;
        amp_d        = amp_q;
        cfg_update_d = 1'b0;
        ack_new      = 1'b0;
        ack_byte     = ACK_E;
        hex_max      = tgt_q ? 4'd8 : 4'd2;
        tmo_d        = (state_q == S_IDLE || rx_valid) ? 32'd0 : tmo_q + 32'd1;

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_d(rx_data)) begin
                        wave_sel_d   = d_map(rx_data);
                        cfg_update_d = 1'b1;
                        ack_new      = 1'b1;
                        ack_byte     = ACK_K;
                    end else if (rx_data == 8'h57) begin
                        state_d = S_W_ARG;
                    end else if (rx_data == 8'h46 || rx_data == 8'h41) begin
                        state_d  = S_HEX_ARG;
                        shadow_d = 32'd0;
                        cnt_d    = 4'd0;
                        tgt_d    = (rx_data == 8'h46);
                    end else if (!is_t(rx_data)) begin
                        ack_new = 1'b1;
                    end
                end
                S_W_ARG: begin
                    if (is_d(rx_data)) begin
                        shadow_d = {27'd0, d_map(rx_data)};
                        state_d  = S_W_END;
                    end else if (is_t(rx_data)) begin
                        ack_new = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_W_END: begin
                    if (is_t(rx_data)) begin
                        wave_sel_d   = shadow_q[4:0];
                        cfg_update_d = 1'b1;
                        ack_new      = 1'b1;
                        ack_byte     = ACK_K;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_HEX_ARG: begin
                    if (is_hex(rx_data)) begin
                        if (cnt_q < hex_max) begin
                            shadow_d = {shadow_q[27:0], hex_nib(rx_data)};
                            cnt_d    = cnt_q + 4'd1;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else if (is_t(rx_data)) begin
                        ack_new = 1'b1;
                        state_d = S_IDLE;
                        if (cnt_q != 4'd0) begin
                            if (tgt_q) freq_word_d = shadow_q;
                            else       amp_d       = shadow_q[7:0];
                            cfg_update_d = 1'b1;
                            ack_byte     = ACK_K;
                        end
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                default: begin
                    if (is_t(rx_data)) begin
                        ack_new = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && tmo_q == TIMEOUT_CYC - 32'd1) begin
            ack_new = 1'b1;
            state_d = S_IDLE;
        end

        // Single-entry ack slot: newest ack always wins, handshake alone drains it.
        tx_data_d  = ack_new ? ack_byte : tx_data_q;
        tx_valid_d = ack_new ? 1'b1 : (tx_valid_q && !tx_ready);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            cnt_q        <= 4'd0;
            shadow_q     <= 32'd0;
            tmo_q        <= 32'd0;
            wave_sel_q   <= 5'd3;
            freq_word_q  <= FREQ_DEFAULT;
            amp_q        <= 8'hFF;
            cfg_update_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            tmo_q        <= tmo_d;
            wave_sel_q   <= wave_sel_d;
            freq_word_q  <= freq_word_d;
            amp_q        <= amp_d;
            cfg_update_q <= cfg_update_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign wave_sel   = wave_sel_q;
    assign freq_word  = freq_word_q;
    assign amp        = amp_q;
    assign cfg_update = cfg_update_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
endmodule
